map_table: RTL and testbench
============================

Name: map_table

Overview:
- Register alias table for the R10K rename stage; sits directly downstream of the free list.
- Consumes the newly allocated physical registers the free list hands out each cycle, and renames up to N instructions per cycle.
- Returns source physical tags with ready bits, plus the old destination tag (T_old) for the ROB, which later returns it to the free list at retire.
- Maintains physical-register ready bits from CDB broadcasts and keeps branch checkpoints for single-cycle mispredict recovery.

Parameters:
- N, `N, rename/CDB width per cycle
- ARCH_REGS, 32, architectural registers; r0 hardwired
- PHYS_REGS, ARCH_REGS+`ROB_SZ, physical registers
- CKPTS, 4, branch checkpoint slots
- Derived: A = $clog2(ARCH_REGS), P = $clog2(PHYS_REGS), C = $clog2(CKPTS)

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- rn_valid  in  [N]  slot i renames this cycle
- rn_dest_arch  in  [N][A]  destination architectural register
- rn_new_phys  in  [N][P]  tag from free list, slot i
- rn_src1_arch, rn_src2_arch  in  [N][A]  source architectural registers
- rn_src1_phys, rn_src2_phys  out  [N][P]  renamed sources
- rn_src1_ready, rn_src2_ready  out  [N]  source value available
- rn_old_phys  out  [N][P]  T_old to ROB
- cdb_valid  in  [N]  completion broadcast
- cdb_phys  in  [N][P]  completing tag
- ckpt_req  in  1  take checkpoint this cycle
- ckpt_slot  in  [$clog2(N)]  checkpoint covers slots 0..ckpt_slot
- ckpt_id  out  [C]  allocated checkpoint id
- ckpt_full  out  1  no free checkpoint
- br_resolve  in  1  branch resolved
- br_mispredict  in  1  qualifies br_resolve
- br_id  in  [C]  checkpoint being resolved

Behaviour:
- Reset: map[i]=i; all ready bits 1; all checkpoints free; ckpt_full=0; ckpt_id=0. All lookup outputs are combinational from reset state.
- Lookup (combinational, same cycle):
  - Slot i's sources see the destination writes of valid slots j<i in the same cycle; the youngest such j wins.
  - rn_old_phys follows the same intra-group rule.
- Ready for a source:
  - Forwarded from an in-group rename: 0.
  - Otherwise: ready[tag] OR (tag matches any valid cdb_phys this cycle).
- Register r0: always phys 0, ready 1. A write to r0 does not update the map; rn_old_phys=0 for that slot.
- Update at posedge for each valid slot with dest≠0:
  - map[dest] <= new_phys; ready[new_phys] <= 0.
  - CDB sets ready[cdb_phys] <= 1 (skipped for tag 0).
  - If the same tag is both renamed and broadcast, the rename clear wins.
- Checkpoint request:
  - ckpt_req with !ckpt_full allocates the lowest free id, driven on ckpt_id the same cycle.
  - Snapshot = map after applying slots 0..ckpt_slot only.
  - The checkpoint records the mask of currently live checkpoints (its older set).
  - ckpt_req while ckpt_full is ignored; upstream must stall.
- Correct resolve (br_resolve, !br_mispredict): free br_id. It is removed from every live checkpoint's older mask.
- Mispredict (br_resolve & br_mispredict):
  - Next cycle, map <= snapshot[br_id].
  - Free br_id and every checkpoint whose older mask contains br_id.
  - Ready bits are not restored.
  - Same-cycle renames and ckpt_req are dropped.
  - Same-cycle CDB updates still apply.
- Resolving a free id is illegal; the bench asserts it never happens.
- Reset mid-operation returns every register, map entry and checkpoint to its reset state.

Optional Feature:
- MAP_TABLE_DEBUG_EN defined: extra outputs debug_map [ARCH_REGS][P], debug_ready [PHYS_REGS], debug_ckpt_live [CKPTS].
- Also prints renames and restores at negedge, unless DC is defined.
- Undefined: these ports and prints are absent; functional behaviour is identical.

Test Plan:
- Reset, then look up r5 and r31 -> phys 5 and 31, both ready=1.
- Rename slot0 r3<-p40 and slot1 r4=r3+r3 in one cycle -> slot1 srcs=p40, ready=0; slot0 old_phys=3. Next cycle map[3]=40.
- With p40 not ready, cdb_phys=40 in the same cycle as a lookup of r3 -> ready=1; ready[40]=1 afterwards.
- ckpt_req with ckpt_slot=0, slot0 r7<-p41, slot1 r7<-p42 -> ckpt_id=0. Mispredict br_id=0 later -> map[7]=41.
- Allocate ids 0,1,2 in order, mispredict id 1 -> ids 1 and 2 freed, id 0 still live, ckpt_full=0.
- Allocate 4 checkpoints -> ckpt_full=1 and a 5th req is ignored. Correct-resolve id 2 -> next req gets id 2.

Source files
------------

// File: rtl/map_table.sv
// rtl/map_table.sv - R10K register alias table: N-wide rename, CDB ready tracking, branch checkpoints
// Optional debug ports and negedge prints: MAP_TABLE_DEBUG_EN (prints suppressed when DC is defined)
`ifndef N
`define N 2
`endif
`ifndef ROB_SZ
`define ROB_SZ 32
`endif

module map_table #(
  parameter int N         = `N,
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = ARCH_REGS + `ROB_SZ,
  parameter int CKPTS     = 4,
  localparam int A = $clog2(ARCH_REGS),
  localparam int P = $clog2(PHYS_REGS),
  localparam int C = $clog2(CKPTS),
  localparam int S = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
`ifdef MAP_TABLE_DEBUG_EN
  output logic [P-1:0]          debug_map [ARCH_REGS],
  output logic [PHYS_REGS-1:0]  debug_ready,
  output logic [CKPTS-1:0]      debug_ckpt_live,
`endif
  input  logic [N-1:0]          rn_valid,
  input  logic [N-1:0][A-1:0]   rn_dest_arch,
  input  logic [N-1:0][P-1:0]   rn_new_phys,
  input  logic [N-1:0][A-1:0]   rn_src1_arch,
  input  logic [N-1:0][A-1:0]   rn_src2_arch,
  output logic [N-1:0][P-1:0]   rn_src1_phys,
  output logic [N-1:0][P-1:0]   rn_src2_phys,
  output logic [N-1:0]          rn_src1_ready,
  output logic [N-1:0]          rn_src2_ready,
  output logic [N-1:0][P-1:0]   rn_old_phys,
  input  logic [N-1:0]          cdb_valid,
  input  logic [N-1:0][P-1:0]   cdb_phys,
  input  logic                  ckpt_req,
  input  logic [S-1:0]          ckpt_slot,
  output logic [C-1:0]          ckpt_id,
  output logic                  ckpt_full,
  input  logic                  br_resolve,
  input  logic                  br_mispredict,
  input  logic [C-1:0]          br_id
);

  logic [P-1:0]         map_q  [ARCH_REGS];
  logic [P-1:0]         map_d  [ARCH_REGS];
  logic [P-1:0]         snap_d [ARCH_REGS];
  logic [P-1:0]         snap_q [CKPTS][ARCH_REGS];
  logic [PHYS_REGS-1:0] ready_q, ready_d, cdb_hit;
  logic [CKPTS-1:0]     live_q, kill;
  logic [CKPTS-1:0]     older_q [CKPTS];
  logic [N-1:0]         wr_en, src1_fwd, src2_fwd;
  logic                 mispredict, alloc;

  assign mispredict = br_resolve & br_mispredict;
  assign alloc      = ckpt_req & ~ckpt_full & ~mispredict;

  always_comb begin
    for (int j = 0; j < N; j++) wr_en[j] = rn_valid[j] && (rn_dest_arch[j] != '0);
  end

  always_comb begin
    cdb_hit = '0;
    for (int k = 0; k < N; k++) if (cdb_valid[k]) cdb_hit[cdb_phys[k]] = 1'b1;
  end

  // Older slots in the group override the table; the youngest writer wins.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rn_src1_phys[i] = map_q[rn_src1_arch[i]];
      rn_src2_phys[i] = map_q[rn_src2_arch[i]];
      rn_old_phys[i]  = map_q[rn_dest_arch[i]];
      src1_fwd[i] = 1'b0;
      src2_fwd[i] = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (wr_en[j]) begin
          if (rn_dest_arch[j] == rn_src1_arch[i]) begin
            rn_src1_phys[i] = rn_new_phys[j];
            src1_fwd[i] = 1'b1;
          end
          if (rn_dest_arch[j] == rn_src2_arch[i]) begin
            rn_src2_phys[i] = rn_new_phys[j];
            src2_fwd[i] = 1'b1;
          end
          if (rn_dest_arch[j] == rn_dest_arch[i]) rn_old_phys[i] = rn_new_phys[j];
        end
      end
      if (rn_src1_arch[i] == '0) rn_src1_phys[i] = '0;
      if (rn_src2_arch[i] == '0) rn_src2_phys[i] = '0;
      if (rn_dest_arch[i] == '0) rn_old_phys[i] = '0;
      rn_src1_ready[i] = (rn_src1_arch[i] == '0) ||
                         (!src1_fwd[i] && (ready_q[rn_src1_phys[i]] || cdb_hit[rn_src1_phys[i]]));
      rn_src2_ready[i] = (rn_src2_arch[i] == '0) ||
                         (!src2_fwd[i] && (ready_q[rn_src2_phys[i]] || cdb_hit[rn_src2_phys[i]]));
    end
  end

  always_comb begin
    ckpt_id = '0;
    for (int k = CKPTS - 1; k >= 0; k--) if (!live_q[k]) ckpt_id = C'(k);
    ckpt_full = &live_q;
  end

  // Snapshot sees only the slots up to and including the branch slot.
  always_comb begin
    for (int a = 0; a < ARCH_REGS; a++) begin
      map_d[a]  = map_q[a];
      snap_d[a] = map_q[a];
    end
    for (int j = 0; j < N; j++) begin
      if (wr_en[j]) begin
        map_d[rn_dest_arch[j]] = rn_new_phys[j];
        if (j <= int'(ckpt_slot)) snap_d[rn_dest_arch[j]] = rn_new_phys[j];
      end
    end
  end

  always_comb begin
    ready_d = ready_q | (cdb_hit & ~PHYS_REGS'(1));
    if (!mispredict)
      for (int j = 0; j < N; j++) if (wr_en[j]) ready_d[rn_new_phys[j]] = 1'b0;
  end

  always_comb begin
    kill = '0;
    if (br_resolve) begin
      kill[br_id] = 1'b1;
      if (br_mispredict)
        for (int k = 0; k < CKPTS; k++) if (older_q[k][br_id]) kill[k] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int a = 0; a < ARCH_REGS; a++) map_q[a] <= P'(a);
      ready_q <= '1;
      live_q  <= '0;
      for (int k = 0; k < CKPTS; k++) begin
        older_q[k] <= '0;
        for (int a = 0; a < ARCH_REGS; a++) snap_q[k][a] <= '0;
      end
    end else begin
      ready_q <= ready_d;
      for (int a = 0; a < ARCH_REGS; a++)
        map_q[a] <= mispredict ? snap_q[br_id][a] : map_d[a];
      live_q <= (live_q & ~kill) | (alloc ? (CKPTS'(1) << ckpt_id) : '0);
      for (int k = 0; k < CKPTS; k++) older_q[k] <= older_q[k] & ~kill;
      if (alloc) begin
        older_q[ckpt_id] <= live_q & ~kill;
        for (int a = 0; a < ARCH_REGS; a++) snap_q[ckpt_id][a] <= snap_d[a];
      end
    end
  end

`ifdef MAP_TABLE_DEBUG_EN
  always_comb begin
    for (int a = 0; a < ARCH_REGS; a++) debug_map[a] = map_q[a];
  end
  assign debug_ready     = ready_q;
  assign debug_ckpt_live = live_q;
`ifndef DC
  always @(negedge clock) begin
    if (!reset) begin
      if (mispredict) $display("map_table: restore ckpt %0d", br_id);
      else
        for (int j = 0; j < N; j++)
          if (wr_en[j]) $display("map_table: slot %0d r%0d <- p%0d", j, rn_dest_arch[j], rn_new_phys[j]);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_map_table.sv
// tb/tb_map_table.sv - scoreboard bench for map_table with directed rename/checkpoint vectors
module tb_map_table;
  localparam int N = 2, AR = 32, PR = 64, CK = 4;
  localparam int A = 5, P = 6, C = 2, S = 1;

  logic clock = 1'b0;
  logic reset;
  logic [N-1:0]        rn_valid;
  logic [N-1:0][A-1:0] rn_dest_arch, rn_src1_arch, rn_src2_arch;
  logic [N-1:0][P-1:0] rn_new_phys, rn_src1_phys, rn_src2_phys, rn_old_phys;
  logic [N-1:0]        rn_src1_ready, rn_src2_ready;
  logic [N-1:0]        cdb_valid;
  logic [N-1:0][P-1:0] cdb_phys;
  logic                ckpt_req, ckpt_full, br_resolve, br_mispredict;
  logic [S-1:0]        ckpt_slot;
  logic [C-1:0]        ckpt_id, br_id;

  map_table #(.N(N), .ARCH_REGS(AR), .PHYS_REGS(PR), .CKPTS(CK)) dut (
    .clock(clock), .reset(reset),
    .rn_valid(rn_valid), .rn_dest_arch(rn_dest_arch), .rn_new_phys(rn_new_phys),
    .rn_src1_arch(rn_src1_arch), .rn_src2_arch(rn_src2_arch),
    .rn_src1_phys(rn_src1_phys), .rn_src2_phys(rn_src2_phys),
    .rn_src1_ready(rn_src1_ready), .rn_src2_ready(rn_src2_ready),
    .rn_old_phys(rn_old_phys), .cdb_valid(cdb_valid), .cdb_phys(cdb_phys),
    .ckpt_req(ckpt_req), .ckpt_slot(ckpt_slot), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
    .br_resolve(br_resolve), .br_mispredict(br_mispredict), .br_id(br_id)
  );

  always #5 clock = ~clock;

  typedef enum int {K_S1P, K_S1R, K_S2P, K_S2R, K_OLD, K_CID, K_FULL} kind_t;
  typedef struct { string name; kind_t kind; int idx; int exp; } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  logic [CK-1:0] mlive = '0;

  function automatic int actual(kind_t k, int i);
    case (k)
      K_S1P:   return int'(rn_src1_phys[i]);
      K_S1R:   return int'(rn_src1_ready[i]);
      K_S2P:   return int'(rn_src2_phys[i]);
      K_S2R:   return int'(rn_src2_ready[i]);
      K_OLD:   return int'(rn_old_phys[i]);
      K_CID:   return int'(ckpt_id);
      default: return int'(ckpt_full);
    endcase
  endfunction

  // Monitor: checks every expectation queued for the current cycle.
  always @(negedge clock) begin
    while (sb.size() > 0) begin
      exp_t e;
      int act;
      e = sb.pop_front();
      act = actual(e.kind, e.idx);
      total++;
      if (act != e.exp) begin
        bad++;
        $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
      end
    end
  end

  task automatic push_exp(string name, kind_t k, int i, int v);
    exp_t e;
    e.name = name; e.kind = k; e.idx = i; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    rn_valid = '0; rn_dest_arch = '0; rn_new_phys = '0;
    rn_src1_arch = '0; rn_src2_arch = '0;
    cdb_valid = '0; cdb_phys = '0;
    ckpt_req = 1'b0; ckpt_slot = '0;
    br_resolve = 1'b0; br_mispredict = 1'b0; br_id = '0;
  endtask

  task automatic ren(int s, int d, int np);
    rn_valid[s] = 1'b1; rn_dest_arch[s] = A'(d); rn_new_phys[s] = P'(np);
  endtask

  task automatic src(int s, int a1, int a2);
    rn_src1_arch[s] = A'(a1); rn_src2_arch[s] = A'(a2);
  endtask

  task automatic resolve(int id, bit mis, logic [CK-1:0] kill_mask);
    assert (mlive[id]) else $error("resolving free checkpoint %0d", id);
    br_resolve = 1'b1; br_mispredict = mis; br_id = C'(id);
    mlive &= ~kill_mask;
  endtask

  task automatic req(int slot, int id);
    ckpt_req = 1'b1; ckpt_slot = S'(slot);
    mlive[id] = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0;
    src(0, 5, 31); src(1, 0, 0);
    push_exp("rst_r5_phys", K_S1P, 0, 5);   push_exp("rst_r5_rdy", K_S1R, 0, 1);
    push_exp("rst_r31_phys", K_S2P, 0, 31); push_exp("rst_r31_rdy", K_S2R, 0, 1);
    push_exp("rst_r0_phys", K_S1P, 1, 0);   push_exp("rst_r0_rdy", K_S1R, 1, 1);
    push_exp("rst_ckpt_id", K_CID, 0, 0);   push_exp("rst_full", K_FULL, 0, 0);

    cyc();
    ren(0, 3, 40); src(0, 1, 2);
    ren(1, 4, 43); src(1, 3, 3);
    push_exp("fwd_s1_phys", K_S1P, 1, 40); push_exp("fwd_s1_rdy", K_S1R, 1, 0);
    push_exp("fwd_s2_phys", K_S2P, 1, 40); push_exp("fwd_s2_rdy", K_S2R, 1, 0);
    push_exp("old_slot0", K_OLD, 0, 3);    push_exp("old_slot1", K_OLD, 1, 4);
    push_exp("plain_r1", K_S1P, 0, 1);     push_exp("plain_r1_rdy", K_S1R, 0, 1);

    cyc();
    src(0, 3, 4);
    push_exp("map3_40", K_S1P, 0, 40); push_exp("rdy40_clr", K_S1R, 0, 0);
    push_exp("map4_43", K_S2P, 0, 43); push_exp("rdy43_clr", K_S2R, 0, 0);

    cyc();
    src(0, 3, 0); cdb_valid[0] = 1'b1; cdb_phys[0] = P'(40);
    push_exp("cdb_bypass_rdy", K_S1R, 0, 1);

    cyc();
    src(0, 3, 4); ren(0, 5, 44); cdb_valid[1] = 1'b1; cdb_phys[1] = P'(44);
    ren(1, 0, 45); src(1, 5, 0);
    push_exp("rdy40_set", K_S1R, 0, 1);    push_exp("rdy43_still0", K_S2R, 0, 0);
    push_exp("old_slot0_r5", K_OLD, 0, 5); push_exp("old_r0_write", K_OLD, 1, 0);
    push_exp("fwd_r5_phys", K_S1P, 1, 44); push_exp("fwd_r5_rdy", K_S1R, 1, 0);

    cyc();
    src(0, 5, 0);
    push_exp("map5_44", K_S1P, 0, 44); push_exp("rename_beats_cdb", K_S1R, 0, 0);
    push_exp("r0_phys", K_S2P, 0, 0);  push_exp("r0_rdy", K_S2R, 0, 1);

    cyc();
    req(0, 0); ren(0, 7, 41); ren(1, 7, 42);
    push_exp("ckpt_first_id", K_CID, 0, 0);
    push_exp("old_r7_s0", K_OLD, 0, 7); push_exp("old_r7_s1", K_OLD, 1, 41);

    cyc();
    src(0, 7, 0);
    push_exp("map7_42", K_S1P, 0, 42); push_exp("ckpt_next_id", K_CID, 0, 1);

    cyc();
    resolve(0, 1'b1, 4'b0001); ren(0, 8, 46); src(1, 7, 0);
    push_exp("pre_restore_r7", K_S1P, 1, 42);

    cyc();
    src(0, 7, 8);
    push_exp("restore_r7_41", K_S1P, 0, 41); push_exp("rdy41_not_restored", K_S1R, 0, 0);
    push_exp("dropped_r8", K_S2P, 0, 8);     push_exp("dropped_r8_rdy", K_S2R, 0, 1);
    push_exp("freed_id0", K_CID, 0, 0);      push_exp("freed_full", K_FULL, 0, 0);

    cyc(); req(0, 0); push_exp("alloc_a", K_CID, 0, 0);
    cyc(); req(0, 1); ren(0, 9, 47); push_exp("alloc_b", K_CID, 0, 1);
    cyc(); req(0, 2); push_exp("alloc_c", K_CID, 0, 2);
    cyc(); resolve(1, 1'b1, 4'b0110); push_exp("pre_mis_id", K_CID, 0, 3);
    cyc();
    src(0, 9, 0); req(0, 1);
    push_exp("mis1_lowest_free", K_CID, 0, 1); push_exp("mis1_not_full", K_FULL, 0, 0);
    push_exp("mis1_r9_47", K_S1P, 0, 47);
    cyc(); req(0, 2); push_exp("id2_was_freed", K_CID, 0, 2);
    cyc(); req(0, 3); push_exp("alloc_id3", K_CID, 0, 3);
    cyc(); ckpt_req = 1'b1; push_exp("full_set", K_FULL, 0, 1);
    cyc(); resolve(2, 1'b0, 4'b0100); push_exp("fifth_ignored", K_FULL, 0, 1);
    cyc(); req(0, 2);
    push_exp("after_correct_full", K_FULL, 0, 0); push_exp("reuse_id2", K_CID, 0, 2);
    cyc(); push_exp("full_again", K_FULL, 0, 1);

    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0; mlive = '0;
    src(0, 7, 9);
    push_exp("mid_rst_r7", K_S1P, 0, 7); push_exp("mid_rst_r7_rdy", K_S1R, 0, 1);
    push_exp("mid_rst_r9", K_S2P, 0, 9); push_exp("mid_rst_r9_rdy", K_S2R, 0, 1);
    push_exp("mid_rst_full", K_FULL, 0, 0); push_exp("mid_rst_id", K_CID, 0, 0);

    cyc();
    cyc();
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d expected %0d", sb.size(), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
